// File: rtl/rv_read_arbiter.sv
// rv_read_arbiter
//
// Round-robin arbiter that merges four ready/valid read-response producers
// (A..D) into a single ready/valid sink. Each accepted beat is captured in a
// one-entry output register together with its error flag and source index,
// so the downstream bridge sees a single well-behaved producer.
//
// Ports
//   S00_AXI_aclk      clock, all state on the rising edge
//   S00_AXI_aresetn   synchronous active-low reset
//   X_rvalid_i        producer X (A..D) has a beat
//   X_rready_o        producer X beat accepted this cycle
//   X_rdata_i         producer X data
//   X_rerror_i        producer X error flag, qualified by X_rvalid_i
//   M_rvalid_o        output register holds a beat
//   M_rready_i        sink accepts the held beat
//   M_rdata_o         registered data
//   M_rerror_o        registered error flag
//   M_src_o           registered source index (A=0 .. D=3)
//
// Configuration
//   RV_READ_ARB_PRIO_A_EN  when defined, producer A wins whenever it is valid
//                          and the slot is free; B..D round-robin when A is
//                          idle. Undefined (default): pure round-robin.

module rv_read_arbiter #(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32
) (
  input  logic                            S00_AXI_aclk,
  input  logic                            S00_AXI_aresetn,

  input  logic                            A_rvalid_i,
  output logic                            A_rready_o,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] A_rdata_i,
  input  logic                            A_rerror_i,

  input  logic                            B_rvalid_i,
  output logic                            B_rready_o,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] B_rdata_i,
  input  logic                            B_rerror_i,

  input  logic                            C_rvalid_i,
  output logic                            C_rready_o,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] C_rdata_i,
  input  logic                            C_rerror_i,

  input  logic                            D_rvalid_i,
  output logic                            D_rready_o,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0] D_rdata_i,
  input  logic                            D_rerror_i,

  output logic                            M_rvalid_o,
  input  logic                            M_rready_i,
  output logic [C_S00_AXI_DATA_WIDTH-1:0] M_rdata_o,
  output logic                            M_rerror_o,
  output logic [1:0]                      M_src_o
);

  localparam int unsigned DW = C_S00_AXI_DATA_WIDTH;

  // Output register and round-robin pointer.
  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q,  err_d;
  logic [1:0]    src_q,  src_d;
  logic [1:0]    last_q, last_d;

  // Producers gathered into indexable form (index 0 = A .. 3 = D).
  logic [3:0]    req;
  logic [3:0]    err_in;
  logic [DW-1:0] data_in [4];

  assign req     = {D_rvalid_i, C_rvalid_i, B_rvalid_i, A_rvalid_i};
  assign err_in  = {D_rerror_i, C_rerror_i, B_rerror_i, A_rerror_i};
  assign data_in[0] = A_rdata_i;
  assign data_in[1] = B_rdata_i;
  assign data_in[2] = C_rdata_i;
  assign data_in[3] = D_rdata_i;

  // Slot can take a new beat when empty or being drained this cycle.
  logic slot_free;
  assign slot_free = !full_q || M_rready_i;

  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic [3:0] gnt_oh;

  // Scan last+1, last+2, last+3, last: the most recent winner is scanned
  // last, so a lone requester is still granted back-to-back.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    if (slot_free && S00_AXI_aresetn) begin
      for (int unsigned k = 1; k <= 4; k++) begin
        cand = last_q + 2'(k);
        if (!gnt_valid && req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
`ifdef RV_READ_ARB_PRIO_A_EN
      // A overrides the rotation; last still moves to 0 below.
      if (req[0]) begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'd0;
      end
`endif
    end
  end

  always_comb begin
    gnt_oh = 4'b0000;
    if (gnt_valid) begin
      gnt_oh = 4'b0001 << gnt_idx;
    end
  end

  assign A_rready_o = gnt_oh[0];
  assign B_rready_o = gnt_oh[1];
  assign C_rready_o = gnt_oh[2];
  assign D_rready_o = gnt_oh[3];

  // Next state: a grant loads the register (covers drain+refill with no
  // bubble); a drain without a grant only clears full, payload holds.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    err_d  = err_q;
    src_d  = src_q;
    last_d = last_q;
    if (gnt_valid) begin
      full_d = 1'b1;
      data_d = data_in[gnt_idx];
      err_d  = err_in[gnt_idx];
      src_d  = gnt_idx;
      last_d = gnt_idx;
    end else if (M_rready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge S00_AXI_aclk) begin
    if (!S00_AXI_aresetn) begin
      full_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
      src_q  <= 2'd0;
      last_q <= 2'd3;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      err_q  <= err_d;
      src_q  <= src_d;
      last_q <= last_d;
    end
  end

  assign M_rvalid_o = full_q;
  assign M_rdata_o  = data_q;
  assign M_rerror_o = err_q;
  assign M_src_o    = src_q;

endmodule

// File: tb/tb_rv_read_arbiter.sv
// Self-checking bench for rv_read_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// arbitration rules kept in the bench.

module tb_rv_read_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    vld;
  logic [3:0]    erv;
  logic [DW-1:0] dat [4];
  logic          m_rready;

  logic [3:0]    rdy;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          m_rerror;
  logic [1:0]    m_src;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit            mdl_full;
  logic [DW-1:0] mdl_data;
  bit            mdl_err;
  int            mdl_src;
  int            mdl_last;

  always #5 clk = ~clk;

  rv_read_arbiter #(
    .C_S00_AXI_DATA_WIDTH (DW)
  ) u_dut (
    .S00_AXI_aclk    (clk),
    .S00_AXI_aresetn (rstn),
    .A_rvalid_i      (vld[0]),
    .A_rready_o      (rdy[0]),
    .A_rdata_i       (dat[0]),
    .A_rerror_i      (erv[0]),
    .B_rvalid_i      (vld[1]),
    .B_rready_o      (rdy[1]),
    .B_rdata_i       (dat[1]),
    .B_rerror_i      (erv[1]),
    .C_rvalid_i      (vld[2]),
    .C_rready_o      (rdy[2]),
    .C_rdata_i       (dat[2]),
    .C_rerror_i      (erv[2]),
    .D_rvalid_i      (vld[3]),
    .D_rready_o      (rdy[3]),
    .D_rdata_i       (dat[3]),
    .D_rerror_i      (erv[3]),
    .M_rvalid_o      (m_rvalid),
    .M_rready_i      (m_rready),
    .M_rdata_o       (m_rdata),
    .M_rerror_o      (m_rerror),
    .M_src_o         (m_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mdl_full = 1'b0;
    mdl_data = '0;
    mdl_err  = 1'b0;
    mdl_src  = 0;
    mdl_last = 3;
  endtask

  // Winning producer index for the current inputs, or -1 for no grant.
  function automatic int mdl_grant();
    int i;
    if (!rstn) return -1;
    if (mdl_full && !m_rready) return -1;
`ifdef RV_READ_ARB_PRIO_A_EN
    if (vld[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      i = (mdl_last + k) % 4;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  // One clock: check combinational and registered outputs against the
  // model, then advance the model across the rising edge.
  task automatic step();
    int         g;
    logic [3:0] exp_rdy;
    #1;
    g       = mdl_grant();
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    check("rready",   64'(rdy),      64'(exp_rdy));
    check("m_rvalid", 64'(m_rvalid), 64'(mdl_full));
    check("m_rdata",  64'(m_rdata),  64'(mdl_data));
    check("m_rerror", 64'(m_rerror), 64'(mdl_err));
    check("m_src",    64'(m_src),    64'(mdl_src));
    @(posedge clk);
    if (!rstn) begin
      mdl_reset();
    end else if (g >= 0) begin
      mdl_full = 1'b1;
      mdl_data = dat[g];
      mdl_err  = erv[g];
      mdl_src  = g;
      mdl_last = g;
    end else if (m_rready) begin
      mdl_full = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rstn     = 1'b0;
    vld      = 4'b0000;
    erv      = 4'b0000;
    m_rready = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    repeat (2) @(posedge clk);
    mdl_reset();
    @(negedge clk);

    // Reset then idle, first request from B.
    step();
    step();
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_src",    64'(m_src),    64'd0);
    rstn = 1'b1;
    step();
    vld      = 4'b0010;
    dat[1]   = 32'h11;
    m_rready = 1'b1;
    step();
    vld = 4'b0000;
    check("b_first_data",  64'(m_rdata),  64'h11);
    check("b_first_src",   64'(m_src),    64'd1);
    check("b_first_valid", 64'(m_rvalid), 64'd1);
    step();

    // All four valid continuously from a fresh reset.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    vld  = 4'b1111;
    for (int i = 0; i < 4; i++) dat[i] = 32'hA0 + i;
    m_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
`ifndef RV_READ_ARB_PRIO_A_EN
      check("rr_seq", 64'(m_src), 64'(i % 4));
`endif
    end

    // Backpressure: C holds 0xCAFE with error while D waits.
    vld      = 4'b0100;
    dat[2]   = 32'hCAFE;
    erv      = 4'b0100;
    step();
    vld      = 4'b1000;
    dat[3]   = 32'hDDDD;
    erv      = 4'b0000;
    dat[2]   = 32'h0;
    m_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_data", 64'(m_rdata),  64'hCAFE);
      check("bp_err",  64'(m_rerror), 64'd1);
    end
    m_rready = 1'b1;
    step();
    check("bp_d_src",  64'(m_src),   64'd3);
    check("bp_d_data", 64'(m_rdata), 64'hDDDD);

    // Lone requester D, back-to-back.
    for (int v = 1; v <= 3; v++) begin
      dat[3] = 32'(v);
      step();
      check("lone_d_data", 64'(m_rdata), 64'(v));
    end
    vld = 4'b0000;
    step();

    // Reset mid-operation discards the held beat.
    vld    = 4'b0001;
    dat[0] = 32'h55;
    step();
    vld      = 4'b0000;
    m_rready = 1'b0;
    check("pre_rst_data", 64'(m_rdata), 64'h55);
    rstn = 1'b0;
    step();
    check("post_rst_valid", 64'(m_rvalid), 64'd0);
    rstn     = 1'b1;
    vld      = 4'b0011;
    m_rready = 1'b1;
    step();
    check("post_rst_src", 64'(m_src), 64'd0);
    vld = 4'b0000;
    step();

`ifdef RV_READ_ARB_PRIO_A_EN
    // A starves B and C; once A drops, B and C alternate.
    vld = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step();
      check("prio_a_src", 64'(m_src), 64'd0);
    end
    vld = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step();
      check("prio_bc_src", 64'(m_src), 64'((i % 2) + 1));
    end
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rstn     = ($urandom_range(0, 40) != 0);
      vld      = 4'($urandom);
      erv      = 4'($urandom);
      m_rready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) dat[i] = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_read_arbiter.md
# rv_read_arbiter

Round-robin arbiter sharing one ready/valid read-response sink among four producers A..D. It sits between four read-data sources and a single user-port read channel of the AXI-lite register bridge (`rvalid`/`rready`/`rdata`/`rerror`). Each accepted beat is held in a one-entry output register together with its error flag and source index. The bridge therefore sees one well-behaved producer.

## Interface
- `C_S00_AXI_DATA_WIDTH`, default 32: data width of all data ports.
- `S00_AXI_aclk`  in  1  sole clock; all state on rising edge.
- `S00_AXI_aresetn`  in  1  reset; synchronous, active-low.
- `X_rvalid_i` (X = A,B,C,D)  in  1  producer X has a beat.
- `X_rready_o`  out  1  producer X beat accepted this cycle.
- `X_rdata_i`  in  C_S00_AXI_DATA_WIDTH  producer X data.
- `X_rerror_i`  in  1  producer X error flag, qualified by `X_rvalid_i`.
- `M_rvalid_o`  out  1  output register holds a beat.
- `M_rready_i`  in  1  sink accepts beat.
- `M_rdata_o`  out  C_S00_AXI_DATA_WIDTH  registered data.
- `M_rerror_o`  out  1  registered error flag.
- `M_src_o`  out  2  registered source index (A=0 … D=3).

## Operation
- State:
  - output register: `full`, data, error, src;
  - 2-bit `last` pointer, the index of the most recently granted producer.
- Slot free: `!full | M_rready_i`. Draining and refilling in the same cycle is allowed.
- Grant (combinational):
  - Only when the slot is free and reset is inactive.
  - Scan indices `last+1, last+2, last+3, last` modulo 4.
  - Grant the first index whose `X_rvalid_i` = 1.
  - Exactly one `X_rready_o` is high when there is a grant; otherwise all are low.
- On a grant, at the clock edge:
  - load data, error and src from the granted producer;
  - set `full` = 1;
  - set `last` = granted index.
- `M_rready_i & full` with no grant: `full` = 0. Data, error and src hold their values.
- `last` changes only on a grant. Wrap-around: `last` = 3 scans 0,1,2,3.
- A lone requester is granted back-to-back, since its own index is scanned last.
- `X_rready_o` may depend on `X_rvalid_i`.
- `M_rvalid_o` never depends on `M_rready_i`.
- Producer data and error are sampled only in the grant cycle. A producer may change them after its handshake.

## Timing
- Reset (`S00_AXI_aresetn` = 0 at an edge) forces:
  - `full` = 0, so `M_rvalid_o` = 0;
  - `M_rdata_o` = 0, `M_rerror_o` = 0, `M_src_o` = 0;
  - `last` = 3.
- While reset is asserted, all `X_rready_o` = 0.
- Reset mid-transfer discards the held beat. A producer handshake cannot occur in a reset cycle.
- Latency: producer handshake at edge n gives `M_rvalid_o` = 1 from edge n onward, i.e. visible in cycle n+1.
- Throughput: one beat per cycle while `M_rready_i` = 1 and any producer is valid.
- Backpressure: `M_rvalid_o` = 1 and `M_rready_i` = 0 gives all `X_rready_o` = 0, with the output register stable.
- Simultaneous drain and grant: new beat loaded; `M_rvalid_o` stays 1 with no bubble.

## Configuration
- `RV_READ_ARB_PRIO_A_EN`:
  - Defined: producer A has fixed priority. If `A_rvalid_i` = 1 and the slot is free, A is granted regardless of `last`, and `last` is still updated to 0. B..D keep round-robin among themselves whenever A is idle. A may starve B..D.
  - Undefined: pure round-robin over all four, as described above.

## Test plan
- Reset then idle:
  - after 2 cycles with `S00_AXI_aresetn` = 0, all outputs are 0 and `M_src_o` = 0;
  - first request from B (data 0x11) -> `B_rready_o` = 1, next cycle `M_rdata_o` = 0x11, `M_src_o` = 1, `M_rvalid_o` = 1.
- All four valid continuously, `M_rready_i` = 1:
  - grants A,B,C,D,A,… one per cycle;
  - `M_src_o` sequence 0,1,2,3,0 with no bubbles.
- Backpressure:
  - C delivers 0xCAFE with `C_rerror_i` = 1, `M_rready_i` held 0 for 5 cycles while D is valid;
  - `M_rdata_o` = 0xCAFE and `M_rerror_o` = 1 stay stable;
  - `D_rready_o` = 0 throughout;
  - D is granted in the cycle `M_rready_i` rises.
- Lone requester D with values 1,2,3 and `M_rready_i` = 1 -> three consecutive grants; `M_rdata_o` 1,2,3.
- Reset mid-operation:
  - assert reset while `M_rvalid_o` = 1 with 0x55;
  - next cycle `M_rvalid_o` = 0;
  - after release with A,B valid, A is granted first.
- `RV_READ_ARB_PRIO_A_EN` defined, A,B,C valid continuously, `M_rready_i` = 1:
  - `M_src_o` = 0 every cycle;
  - drop A -> B, C alternate.
